// File: rtl/operand_forward_stage.sv
// operand_forward_stage: resolves forwarded SR/TR operands into the X-stage register, with stall/forward counters
module operand_forward_stage #(
  parameter logic [15:0] NOP_INST = 16'hC0E0,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_r,
  input  logic             en_x,
  input  logic [15:0]      inst_r,
  input  logic             valid_r,
  input  logic [15:0]      rf_sr,
  input  logic [15:0]      rf_tr,
  input  logic [4:0]       forwarding_sr,
  input  logic [4:0]       forwarding_tr,
  input  logic [15:0]      alu_x,
  input  logic [15:0]      alu_m,
  input  logic [15:0]      mem_m,
  input  logic [15:0]      alu_w,
  input  logic [15:0]      mem_w,
  output logic [15:0]      inst_x,
  output logic             valid_x,
  output logic [15:0]      sr_x,
  output logic [15:0]      tr_x,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] fwd_cnt
);
  logic [15:0] sr_sel, tr_sel;
  logic        capture, fwd_hit;
  always_comb begin
    sr_sel  = forwarding_sr[4] ? alu_x : forwarding_sr[3] ? alu_m : forwarding_sr[2] ? mem_m :
              forwarding_sr[1] ? alu_w : forwarding_sr[0] ? mem_w : rf_sr;
    tr_sel  = forwarding_tr[4] ? alu_x : forwarding_tr[3] ? alu_m : forwarding_tr[2] ? mem_m :
              forwarding_tr[1] ? alu_w : forwarding_tr[0] ? mem_w : rf_tr;
    capture = en_x & en_r;
    fwd_hit = capture & valid_r & (|{forwarding_sr, forwarding_tr});
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_x    <= NOP_INST;
      valid_x   <= 1'b0;
      sr_x      <= '0;
      tr_x      <= '0;
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (en_x) begin
        inst_x  <= en_r ? inst_r : NOP_INST;
        valid_x <= en_r & valid_r;
        sr_x    <= en_r ? sr_sel : '0;
        tr_x    <= en_r ? tr_sel : '0;
      end
      if (!en_r && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (fwd_hit && !(&fwd_cnt)) fwd_cnt <= fwd_cnt + 1'b1;
    end
  end
endmodule

// File: doc/operand_forward_stage.md
OPERAND_FORWARD_STAGE -- requirements
Module: operand_forward_stage

Interface
REQ-001 Parameter: NOP_INST, 16'hC0E0, instruction word injected into X on a bubble.
REQ-002 Parameter: CNT_W, 16, width of the stall and forward performance counters.
REQ-003 Port: clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 Port: rst  in  1  synchronous reset, active-high.
REQ-005 Port: en_r  in  1  R-stage enable from the pipeline controller; 0 = R stalled.
REQ-006 Port: en_x  in  1  X-stage enable from the pipeline controller; 0 = X holds.
REQ-007 Port: inst_r  in  16  instruction in R.
REQ-008 Port: valid_r  in  1  inst_r is a real instruction.
REQ-009 Port: rf_sr, rf_tr  in  16 each  register-file read data for the SR and TR operands.
REQ-010 Port: forwarding_sr, forwarding_tr  in  5 each  one bit per source, ordered {x_alu, m_alu, m_mem, w_alu, w_mem}.
REQ-011 Port: alu_x, alu_m, mem_m, alu_w, mem_w  in  16 each  candidate forward data.
REQ-012 Port: inst_x  out  16  registered instruction for X.
REQ-013 Port: valid_x  out  1  registered valid for X.
REQ-014 Port: sr_x, tr_x  out  16 each  registered resolved operands for X.
REQ-015 Port: stall_cnt, fwd_cnt  out  CNT_W each  saturating performance counters.

Function
REQ-016 The block SHALL select each operand combinationally by fixed priority: x_alu > m_alu > m_mem > w_alu > w_mem > register file.
REQ-017 The SR and TR selections SHALL be independent, each driven only by its own forwarding vector.
REQ-018 Multi-hot forwarding vectors are legal; the highest-priority set bit always wins, with no error reported.
REQ-019 Capture: en_x=1 and en_r=1 -> next edge loads inst_x=inst_r, valid_x=valid_r, sr_x and tr_x = the selected operands (latency 1 cycle).
REQ-020 Bubble: en_x=1 and en_r=0 -> next edge loads inst_x=NOP_INST, valid_x=0, sr_x=0, tr_x=0.
REQ-021 Hold: en_x=0 -> inst_x, valid_x, sr_x and tr_x keep their values, regardless of en_r.
REQ-022 stall_cnt SHALL increment on every non-reset edge where en_r=0, independent of en_x.
REQ-023 fwd_cnt SHALL increment on every capture edge (REQ-019) where valid_r=1 and any bit of forwarding_sr or forwarding_tr is set.
REQ-024 Both counters SHALL saturate at all-ones and never wrap.
REQ-025 Both counters SHALL increment at most once per edge.
REQ-026 Forward data is consumed only on capture edges; the stage keeps no other internal state.

Reset
REQ-027 When rst=1 at an edge: inst_x=NOP_INST, valid_x=0, sr_x=0, tr_x=0, stall_cnt=0, fwd_cnt=0.
REQ-028 Reset SHALL override en_r, en_x and all data inputs.
REQ-029 Reset asserted mid-stall or mid-hold SHALL discard the held instruction; no counter increments on a reset edge.
REQ-030 First capture is permitted on the first edge after rst deasserts.

Verification
REQ-031 Plain capture: rst, then en_r=en_x=1, inst_r=16'h1234, valid_r=1, rf_sr=16'h0011, rf_tr=16'h0022, forwarding vectors=0 -> after one edge inst_x=16'h1234, valid_x=1, sr_x=16'h0011, tr_x=16'h0022, fwd_cnt=0.
REQ-032 Priority: forwarding_sr=5'b01101, alu_m=16'hAAAA, mem_m=16'hBBBB, alu_w=16'hCCCC; forwarding_tr=5'b00001, mem_w=16'h5555 -> sr_x=16'hAAAA, tr_x=16'h5555, fwd_cnt increments by 1.
REQ-033 Bubble: en_r=0, en_x=1 for 2 edges -> inst_x=NOP_INST, valid_x=0, sr_x=tr_x=0, stall_cnt=2.
REQ-034 Hold: capture 16'h1234, then en_x=0, en_r=0 for 3 edges with changing inputs -> outputs stay 16'h1234/valid 1, stall_cnt=3.
REQ-035 Saturation: CNT_W=4, en_r=0 for 20 edges -> stall_cnt=4'hF and stays there.
REQ-036 Reset mid-operation: rst=1 for one edge during a hold with counters nonzero -> all outputs at reset values; next capture edge behaves as in REQ-031.
